// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester Data_Memory port arbiter.
// Holds the FSM encoding, requester indices and default bus widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    TURN   = 2'd3
  } arb_state_t;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 256;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: combinational choice against the last winner, pointer updated on strobe.
// Zero-latency pick; the pointer only moves when the caller commits a grant via update.
module rr_arbiter_2
  import mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant_vld,
  output logic       grant_idx
);

  logic last_grant;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    grant_vld = |req;
    grant_idx = (req == 2'b11) ? ~last_grant : req[1];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_grant <= REQ_DCACHE;
    end else if (update && grant_vld) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one Data_Memory line port between icache (0) and dcache (1); grant to mem_enable_o is 1 cycle.
// Requesters hold enable until their ack; a one-cycle TURN gap follows every memory ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int LINE_W         = DEF_LINE_W,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              r0_enable_i,
  input  logic              r0_write_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [LINE_W-1:0] r0_data_i,
  output logic              r0_ack_o,
  output logic [LINE_W-1:0] r0_data_o,
  input  logic              r1_enable_i,
  input  logic              r1_write_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [LINE_W-1:0] r1_data_i,
  output logic              r1_ack_o,
  output logic [LINE_W-1:0] r1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              timeout_o
);

  localparam logic [CNT_W-1:0] WD_MAX  = '1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state_q, state_d;
  logic             arb_update;
  logic             pick_vld;
  logic             pick_idx;
  logic             in_grant;
  logic [CNT_W-1:0] wd_cnt;

  rr_arbiter_2 u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req       ({r1_enable_i, r0_enable_i}),
    .update    (arb_update),
    .grant_vld (pick_vld),
    .grant_idx (pick_idx)
  );

  assign in_grant = (state_q == GRANT0) || (state_q == GRANT1);

  always_comb begin
    state_d    = state_q;
    arb_update = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          arb_update = 1'b1;
          state_d    = (pick_idx == REQ_DCACHE) ? GRANT1 : GRANT0;
        end
      end
      GRANT0, GRANT1: begin
        if (mem_ack_i) state_d = TURN;
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      wd_cnt       <= '0;
      timeout_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (arb_update) begin
        mem_enable_o <= 1'b1;
        mem_write_o  <= (pick_idx == REQ_DCACHE) ? r1_write_i : r0_write_i;
        mem_addr_o   <= (pick_idx == REQ_DCACHE) ? r1_addr_i  : r0_addr_i;
        mem_data_o   <= (pick_idx == REQ_DCACHE) ? r1_data_i  : r0_data_i;
        wd_cnt       <= '0;
      end else if (in_grant) begin
        if (mem_ack_i) begin
          mem_enable_o <= 1'b0;
          mem_write_o  <= 1'b0;
        end
        if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + CNT_W'(1);
        // Flag lands on the cycle the count reaches the bound; the grant itself stays put.
        if (!mem_ack_i && wd_cnt == WD_LAST) timeout_o <= 1'b1;
      end
    end
  end

  assign r0_ack_o  = (state_q == GRANT0) && mem_ack_i;
  assign r1_ack_o  = (state_q == GRANT1) && mem_ack_i;
  assign r0_data_o = mem_data_i;
  assign r1_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of grant order, turnaround timing and ack routing.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 64;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          r0_enable_i, r0_write_i, r1_enable_i, r1_write_i;
  logic [AW-1:0] r0_addr_i, r1_addr_i;
  logic [LW-1:0] r0_data_i, r1_data_i;
  logic          r0_ack_o, r1_ack_o;
  logic [LW-1:0] r0_data_o, r1_data_o;
  logic          mem_enable_o, mem_write_o, mem_ack_i, timeout_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_data_o, mem_data_i;

  int vec  = 0;
  int errs = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .r0_enable_i(r0_enable_i), .r0_write_i(r0_write_i), .r0_addr_i(r0_addr_i),
    .r0_data_i(r0_data_i), .r0_ack_o(r0_ack_o), .r0_data_o(r0_data_o),
    .r1_enable_i(r1_enable_i), .r1_write_i(r1_write_i), .r1_addr_i(r1_addr_i),
    .r1_data_i(r1_data_i), .r1_ack_o(r1_ack_o), .r1_data_o(r1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .timeout_o(timeout_o)
  );

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    r0_enable_i = 0; r0_write_i = 0; r0_addr_i = '0; r0_data_i = '0;
    r1_enable_i = 0; r1_write_i = 0; r1_addr_i = '0; r1_data_i = '0;
    mem_ack_i = 0; mem_data_i = '0;
  endtask

  task automatic do_reset();
    rst_i = 0;
    clear_inputs();
    repeat (2) tick();
    rst_i = 1;
  endtask

  task automatic test_reset();
    rst_i = 0;
    clear_inputs();
    @(negedge clk_i);
    vec++; if ({mem_enable_o, mem_write_o, timeout_o} !== 3'b000) begin
      errs++; $display("FAIL reset_ctrl: got en/wr/to=%b want 000", {mem_enable_o, mem_write_o, timeout_o});
    end
    vec++; if (mem_addr_o !== '0 || mem_data_o !== '0) begin
      errs++; $display("FAIL reset_bus: got addr=%h data=%h want 0", mem_addr_o, mem_data_o);
    end
    tick();
    rst_i = 1;
    tick();
    mem_ack_i = 1;
    mem_data_i = rand_line();
    @(negedge clk_i);
    vec++; if ({r1_ack_o, r0_ack_o} !== 2'b00) begin
      errs++; $display("FAIL stray_ack: got acks=%b want 00", {r1_ack_o, r0_ack_o});
    end
    vec++; if (r0_data_o !== mem_data_i || r1_data_o !== mem_data_i) begin
      errs++; $display("FAIL data_pass: got r0=%h want %h", r0_data_o, mem_data_i);
    end
    tick();
    mem_ack_i = 0;
  endtask

  task automatic test_single_r1();
    logic [LW-1:0] line;
    line = {16{16'hECFA}};
    do_reset();
    r1_enable_i = 1; r1_write_i = 0; r1_addr_i = 32'h0000_0040;
    @(negedge clk_i);
    vec++; if (mem_enable_o !== 1'b0) begin
      errs++; $display("FAIL single_early: got en=%b want 0", mem_enable_o);
    end
    tick();
    @(negedge clk_i);
    vec++; if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h40 || mem_write_o !== 1'b0) begin
      errs++; $display("FAIL single_grant: got en=%b addr=%h wr=%b want 1 40 0", mem_enable_o, mem_addr_o, mem_write_o);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      @(negedge clk_i);
      vec++; if ({r1_ack_o, r0_ack_o} !== 2'b00) begin
        errs++; $display("FAIL single_wait: got acks=%b want 00 at %0d", {r1_ack_o, r0_ack_o}, i);
      end
    end
    tick();
    mem_ack_i = 1; mem_data_i = line;
    @(negedge clk_i);
    vec++; if ({r1_ack_o, r0_ack_o} !== 2'b10 || r1_data_o !== line) begin
      errs++; $display("FAIL single_ack: got acks=%b data=%h want 10 %h", {r1_ack_o, r0_ack_o}, r1_data_o, line);
    end
    tick();
    mem_ack_i = 0; r1_enable_i = 0;
    @(negedge clk_i);
    vec++; if (mem_enable_o !== 1'b0 || r1_ack_o !== 1'b0) begin
      errs++; $display("FAIL single_turn: got en=%b ack=%b want 0 0", mem_enable_o, r1_ack_o);
    end
    tick();
  endtask

  task automatic test_tie();
    do_reset();
    r0_enable_i = 1; r0_addr_i = 32'h100;
    r1_enable_i = 1; r1_addr_i = 32'h300;
    tick();
    @(negedge clk_i);
    vec++; if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h100) begin
      errs++; $display("FAIL tie_first: got en=%b addr=%h want 1 100", mem_enable_o, mem_addr_o);
    end
    tick();
    mem_ack_i = 1;
    @(negedge clk_i);
    vec++; if ({r1_ack_o, r0_ack_o} !== 2'b01) begin
      errs++; $display("FAIL tie_ack0: got acks=%b want 01", {r1_ack_o, r0_ack_o});
    end
    tick();
    mem_ack_i = 0; r0_enable_i = 0;
    @(negedge clk_i);
    vec++; if (mem_enable_o !== 1'b0) begin
      errs++; $display("FAIL tie_gap1: got en=%b want 0", mem_enable_o);
    end
    tick();
    @(negedge clk_i);
    vec++; if (mem_enable_o !== 1'b0) begin
      errs++; $display("FAIL tie_gap2: got en=%b want 0", mem_enable_o);
    end
    tick();
    @(negedge clk_i);
    vec++; if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h300) begin
      errs++; $display("FAIL tie_second: got en=%b addr=%h want 1 300", mem_enable_o, mem_addr_o);
    end
    tick();
    mem_ack_i = 1;
    @(negedge clk_i);
    vec++; if ({r1_ack_o, r0_ack_o} !== 2'b10) begin
      errs++; $display("FAIL tie_ack1: got acks=%b want 10", {r1_ack_o, r0_ack_o});
    end
    tick();
    mem_ack_i = 0; r1_enable_i = 0;
    tick();
  endtask

  task automatic test_fairness();
    int w;
    int who;
    do_reset();
    r0_enable_i = 1; r0_addr_i = 32'h1000;
    r1_enable_i = 1; r1_addr_i = 32'h2000;
    for (int t = 0; t < 6; t++) begin
      w = 0;
      @(negedge clk_i);
      while (!mem_enable_o && w < 8) begin
        @(negedge clk_i);
        w++;
      end
      vec++; if (mem_enable_o !== 1'b1) begin
        errs++; $display("FAIL fair_wait: no grant for txn %0d", t);
      end
      vec++; if (mem_addr_o !== ((t % 2 == 0) ? 32'h1000 : 32'h2000)) begin
        errs++; $display("FAIL fair_order: txn %0d got addr=%h want owner %0d", t, mem_addr_o, t % 2);
      end
      who = (mem_addr_o == 32'h2000) ? 1 : 0;
      tick();
      mem_ack_i = 1;
      tick();
      mem_ack_i = 0;
      if (who == 1) r1_enable_i = 0; else r0_enable_i = 0;
      tick();
      r0_enable_i = 1; r1_enable_i = 1;
    end
    r0_enable_i = 0; r1_enable_i = 0;
    repeat (4) tick();
  endtask

  task automatic test_hold();
    logic [LW-1:0] line;
    line = {8{32'h0123_4567}};
    do_reset();
    r1_enable_i = 1; r1_write_i = 1; r1_addr_i = 32'h200; r1_data_i = line;
    tick();
    @(negedge clk_i);
    vec++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_data_o !== line) begin
      errs++; $display("FAIL hold_grant: got en=%b wr=%b addr=%h", mem_enable_o, mem_write_o, mem_addr_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      r1_addr_i = 32'h400; r1_write_i = 0; r1_data_i = ~line;
      @(negedge clk_i);
      vec++; if (mem_addr_o !== 32'h200 || mem_write_o !== 1'b1 || mem_data_o !== line) begin
        errs++; $display("FAIL hold_stable: got addr=%h wr=%b want 200 1", mem_addr_o, mem_write_o);
      end
    end
    tick();
    mem_ack_i = 1;
    @(negedge clk_i);
    vec++; if (r1_ack_o !== 1'b1 || mem_write_o !== 1'b1) begin
      errs++; $display("FAIL hold_ack: got ack=%b wr=%b want 1 1", r1_ack_o, mem_write_o);
    end
    tick();
    mem_ack_i = 0; r1_enable_i = 0;
    @(negedge clk_i);
    vec++; if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin
      errs++; $display("FAIL hold_release: got en=%b wr=%b want 0 0", mem_enable_o, mem_write_o);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    r0_enable_i = 1; r0_addr_i = 32'h80;
    tick();
    for (int k = 0; k <= TO; k++) begin
      @(negedge clk_i);
      vec++; if (timeout_o !== (k >= TO) || mem_enable_o !== 1'b1) begin
        errs++; $display("FAIL timeout_edge: cycle %0d got to=%b en=%b want %b 1", k, timeout_o, mem_enable_o, (k >= TO));
      end
    end
    repeat (5) @(negedge clk_i);
    vec++; if (timeout_o !== 1'b1 || mem_enable_o !== 1'b1 || mem_addr_o !== 32'h80) begin
      errs++; $display("FAIL timeout_sticky: got to=%b en=%b want 1 1", timeout_o, mem_enable_o);
    end
    rst_i = 0;
    #1;
    vec++; if (timeout_o !== 1'b0 || mem_enable_o !== 1'b0) begin
      errs++; $display("FAIL timeout_clear: got to=%b en=%b want 0 0", timeout_o, mem_enable_o);
    end
    r0_enable_i = 0;
    tick();
    rst_i = 1;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    r0_enable_i = 1; r0_write_i = 1; r0_addr_i = 32'h500; r0_data_i = rand_line();
    tick();
    @(negedge clk_i);
    vec++; if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h500) begin
      errs++; $display("FAIL arst_grant: got en=%b addr=%h want 1 500", mem_enable_o, mem_addr_o);
    end
    #2;
    rst_i = 0; mem_ack_i = 1;
    #1;
    vec++; if ({mem_enable_o, mem_write_o} !== 2'b00 || mem_addr_o !== '0 || mem_data_o !== '0) begin
      errs++; $display("FAIL arst_async: got en=%b wr=%b addr=%h want all 0", mem_enable_o, mem_write_o, mem_addr_o);
    end
    vec++; if ({r1_ack_o, r0_ack_o} !== 2'b00) begin
      errs++; $display("FAIL arst_noack: got acks=%b want 00", {r1_ack_o, r0_ack_o});
    end
    tick();
    rst_i = 1; mem_ack_i = 0; r0_enable_i = 0; r0_write_i = 0;
    r1_enable_i = 1; r1_addr_i = 32'h600;
    @(negedge clk_i);
    vec++; if (mem_enable_o !== 1'b0) begin
      errs++; $display("FAIL arst_idle: got en=%b want 0", mem_enable_o);
    end
    tick();
    @(negedge clk_i);
    vec++; if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h600) begin
      errs++; $display("FAIL arst_regrant: got en=%b addr=%h want 1 600", mem_enable_o, mem_addr_o);
    end
    tick();
    mem_ack_i = 1;
    @(negedge clk_i);
    vec++; if ({r1_ack_o, r0_ack_o} !== 2'b10) begin
      errs++; $display("FAIL arst_ack: got acks=%b want 10", {r1_ack_o, r0_ack_o});
    end
    tick();
    mem_ack_i = 0; r1_enable_i = 0;
    tick();
  endtask

  task automatic test_random();
    logic [1:0]    en, wr, done;
    logic [AW-1:0] ad [2];
    logic [LW-1:0] dt [2];
    int            gap [2];
    bit            busy, exp_rise, macked;
    int            owner, mlast, ready_t, exp_own, mwait, grants;
    logic          exp_wr;
    logic [AW-1:0] exp_ad;
    logic [LW-1:0] exp_dt;
    do_reset();
    en = 0; wr = 0; done = 0; gap[0] = 0; gap[1] = 0;
    ad[0] = '0; ad[1] = '0; dt[0] = '0; dt[1] = '0;
    busy = 0; exp_rise = 0; macked = 0; owner = 0; mlast = 1; ready_t = 0;
    exp_own = 0; mwait = 0; grants = 0; exp_wr = 0; exp_ad = '0; exp_dt = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (done[k]) begin
          en[k] = 0; done[k] = 0; gap[k] = $urandom_range(1, 4);
        end else if (!en[k]) begin
          if (gap[k] > 0) gap[k]--;
          else begin
            en[k] = ($urandom_range(0, 2) != 0);
            wr[k] = 1'($urandom);
            ad[k] = $urandom;
            dt[k] = rand_line();
          end
        end
      end
      r0_enable_i = en[0]; r0_write_i = wr[0]; r0_addr_i = ad[0]; r0_data_i = dt[0];
      r1_enable_i = en[1]; r1_write_i = wr[1]; r1_addr_i = ad[1]; r1_data_i = dt[1];
      mem_data_i = rand_line();
      mem_ack_i  = 0;
      if (mem_enable_o && !macked) begin
        if (mwait == 0) begin
          mem_ack_i = 1; macked = 1;
        end else mwait--;
      end else if (!mem_enable_o) begin
        macked = 0; mwait = $urandom_range(0, 5);
      end
      @(negedge clk_i);
      if (exp_rise) begin
        vec++; if (mem_enable_o !== 1'b1 || mem_addr_o !== exp_ad || mem_write_o !== exp_wr || mem_data_o !== exp_dt) begin
          errs++; $display("FAIL rand_grant: cyc %0d got en=%b addr=%h want owner %0d addr=%h", cyc, mem_enable_o, mem_addr_o, exp_own, exp_ad);
        end
        busy = 1; owner = exp_own; mlast = exp_own; exp_rise = 0; grants++;
      end else if (!busy) begin
        vec++; if (mem_enable_o !== 1'b0) begin
          errs++; $display("FAIL rand_idle: cyc %0d got en=%b want 0", cyc, mem_enable_o);
        end
      end else begin
        vec++; if (mem_enable_o !== 1'b1 || mem_addr_o !== exp_ad || mem_write_o !== exp_wr || mem_data_o !== exp_dt) begin
          errs++; $display("FAIL rand_hold: cyc %0d got en=%b addr=%h want 1 %h", cyc, mem_enable_o, mem_addr_o, exp_ad);
        end
      end
      if (busy && mem_ack_i) begin
        vec++; if ({r1_ack_o, r0_ack_o} !== ((owner == 1) ? 2'b10 : 2'b01)) begin
          errs++; $display("FAIL rand_ack: cyc %0d got acks=%b want owner %0d", cyc, {r1_ack_o, r0_ack_o}, owner);
        end
        busy = 0; done[owner] = 1; ready_t = cyc + 2;
      end else begin
        vec++; if ({r1_ack_o, r0_ack_o} !== 2'b00) begin
          errs++; $display("FAIL rand_noack: cyc %0d got acks=%b want 00", cyc, {r1_ack_o, r0_ack_o});
        end
      end
      vec++; if (r0_data_o !== mem_data_i || r1_data_o !== mem_data_i) begin
        errs++; $display("FAIL rand_data: cyc %0d got r0=%h want %h", cyc, r0_data_o, mem_data_i);
      end
      // Next grant: earliest two cycles after an ack, tie broken away from the previous winner.
      if (!busy && cyc >= ready_t && en != 2'b00) begin
        exp_rise = 1;
        exp_own  = (en == 2'b11) ? (1 - mlast) : (en[1] ? 1 : 0);
        exp_wr   = wr[exp_own];
        exp_ad   = ad[exp_own];
        exp_dt   = dt[exp_own];
      end
    end
    vec++; if (grants < 100) begin
      errs++; $display("FAIL rand_activity: got %0d grants want at least 100", grants);
    end
  endtask

  initial begin
    rst_i = 0;
    clear_inputs();
    test_reset();
    test_single_r1();
    test_tie();
    test_fairness();
    test_hold();
    test_timeout();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
